// File: rtl/timebase_pkg.sv
// Shared definitions for the board timebase: FSM encodings and divider sizing helpers.
package timebase_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_STEP  = 2'd3
   } state_e;

   function automatic int calc_div(input int clk_hz, input int fast_hz);
      return clk_hz / fast_hz;
   endfunction

   // Smallest width whose range covers a modulo-n count (2^w >= n).
   function automatic int calc_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with synchronous clear; tc flags the wrapping count.
module mod_counter #(
   parameter int N = 10,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc  = en && (cnt_q == W'(N - 1));
   assign cnt = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)      cnt_d = '0;
      else if (tc)  cnt_d = '0;
      else if (en)  cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/timebase_ctrl.sv
// Run/pause/single-step timebase: one prescaler plus slow counter producing
// clock-enable ticks and LED square waves, all outputs registered.
module timebase_ctrl
   import timebase_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int FAST_HZ  = 10,
   parameter int SLOW_DIV = 10,
   parameter int PRE_W    = 23,
   parameter int SLW_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       clear,
   input  logic       step,
   input  logic       sel_slow,
   output logic       tick_fast,
   output logic       tick_slow,
   output logic       tick_sel,
   output logic       sq_fast,
   output logic       sq_slow,
   output logic [1:0] state
);

   localparam int DIV = calc_div(CLK_HZ, FAST_HZ);

   if (CLK_HZ % FAST_HZ != 0) begin : g_err_ratio
      $error("timebase_ctrl: CLK_HZ must be an integer multiple of FAST_HZ");
   end
   if (DIV < 2) begin : g_err_div
      $error("timebase_ctrl: CLK_HZ/FAST_HZ must be at least 2");
   end
   if (SLOW_DIV < 2) begin : g_err_slow
      $error("timebase_ctrl: SLOW_DIV must be at least 2");
   end
   if (PRE_W < calc_width(DIV)) begin : g_err_prew
      $error("timebase_ctrl: PRE_W too narrow for DIV");
   end
   if (SLW_W < calc_width(SLOW_DIV)) begin : g_err_slww
      $error("timebase_ctrl: SLW_W too narrow for SLOW_DIV");
   end

   state_e           state_q, state_d;
   logic             step_q, sel_q, sel_d;
   logic             tick_fast_q, tick_fast_d, tick_slow_q, tick_slow_d;
   logic             tick_sel_q, tick_sel_d, sq_fast_q, sq_fast_d, sq_slow_q, sq_slow_d;
   logic             pre_clr, pre_en, pre_tc, slw_clr, slw_en, slw_tc;
   logic             fast_evt, step_rise;
   logic [PRE_W-1:0] pre_cnt, pre_nxt;
   logic [SLW_W-1:0] slw_cnt, slw_nxt;

   assign step_rise = step & ~step_q;

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (run) state_d = ST_RUN;
            ST_RUN:   if (!run) state_d = ST_PAUSE;
            ST_PAUSE: if (run) state_d = ST_RUN;
                      else if (step_rise) state_d = ST_STEP;
            ST_STEP:  state_d = ST_PAUSE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // A STEP cycle behaves like a prescaler wrap: it zeroes the count and feeds the slow chain.
   assign pre_en   = (state_q == ST_RUN) & ~clear;
   assign pre_clr  = clear | (state_q == ST_IDLE) | (state_q == ST_STEP);
   assign fast_evt = pre_tc | ((state_q == ST_STEP) & ~clear);
   assign slw_en   = fast_evt;
   assign slw_clr  = clear | (state_q == ST_IDLE);

   mod_counter #(.N(DIV), .W(PRE_W)) u_pre (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (pre_clr),
      .en    (pre_en),
      .cnt   (pre_cnt),
      .tc    (pre_tc)
   );

   mod_counter #(.N(SLOW_DIV), .W(SLW_W)) u_slw (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (slw_clr),
      .en    (slw_en),
      .cnt   (slw_cnt),
      .tc    (slw_tc)
   );

   // Squares are registered from the counts the counters will hold next cycle.
   always_comb begin
      pre_nxt = pre_cnt;
      if (pre_clr || pre_tc) pre_nxt = '0;
      else if (pre_en)       pre_nxt = pre_cnt + 1'b1;
      slw_nxt = slw_cnt;
      if (slw_clr || slw_tc) slw_nxt = '0;
      else if (slw_en)       slw_nxt = slw_cnt + 1'b1;

      tick_fast_d = fast_evt;
      tick_slow_d = slw_tc;
      tick_sel_d  = sel_q ? slw_tc : fast_evt;
      sq_fast_d   = (pre_nxt < PRE_W'(DIV / 2));
      sq_slow_d   = (slw_nxt < SLW_W'(SLOW_DIV / 2));
      sel_d       = ((state_q == ST_IDLE) || fast_evt) ? sel_slow : sel_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         step_q      <= 1'b0;
         sel_q       <= 1'b0;
         tick_fast_q <= 1'b0;
         tick_slow_q <= 1'b0;
         tick_sel_q  <= 1'b0;
         sq_fast_q   <= 1'b1;
         sq_slow_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         step_q      <= step;
         sel_q       <= sel_d;
         tick_fast_q <= tick_fast_d;
         tick_slow_q <= tick_slow_d;
         tick_sel_q  <= tick_sel_d;
         sq_fast_q   <= sq_fast_d;
         sq_slow_q   <= sq_slow_d;
      end
   end

   assign tick_fast = tick_fast_q;
   assign tick_slow = tick_slow_q;
   assign tick_sel  = tick_sel_q;
   assign sq_fast   = sq_fast_q;
   assign sq_slow   = sq_slow_q;
   assign state     = state_q;

endmodule

// File: tb/tb_timebase_ctrl.sv
// Scoreboard bench for timebase_ctrl with DIV=10, SLOW_DIV=4: stimulus queues
// hand-computed tick cycles, a negedge monitor matches every tick against them.
module tb_timebase_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       run = 1'b0, clear = 1'b0, step = 1'b0, sel_slow = 1'b0;
   logic       tick_fast, tick_slow, tick_sel, sq_fast, sq_slow;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int at;
      bit slow;
      bit sel;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   timebase_ctrl #(
      .CLK_HZ(100), .FAST_HZ(10), .SLOW_DIV(4), .PRE_W(4), .SLW_W(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .clear     (clear),
      .step      (step),
      .sel_slow  (sel_slow),
      .tick_fast (tick_fast),
      .tick_slow (tick_slow),
      .tick_sel  (tick_sel),
      .sq_fast   (sq_fast),
      .sq_slow   (sq_slow),
      .state     (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int at, input bit slow, input bit sel);
      exp_t e;
      e.at = at; e.slow = slow; e.sel = sel;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: cycle %0d got %0d, required %0d", name, cyc, act, req);
      end else begin
         $display("check %s: cycle %0d value %0d ok", name, cyc, act);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: overdue entries are missed ticks; any tick output pops one entry.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
         mon_e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL tick_missing: cycle %0d passed with no tick, required tick at %0d",
                  cyc, mon_e.at);
      end
      if (tick_fast || tick_slow || tick_sel) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tick_unexpected: cycle %0d fast/slow/sel=%b%b%b, required no tick",
                     cyc, tick_fast, tick_slow, tick_sel);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.at != cyc || tick_fast !== 1'b1 || tick_slow !== mon_e.slow
                || tick_sel !== mon_e.sel) begin
               errors++;
               $display("FAIL tick_seq: cycle %0d fast/slow/sel=%b%b%b, required cycle %0d fast/slow/sel=1%b%b",
                        cyc, tick_fast, tick_slow, tick_sel, mon_e.at, mon_e.slow, mon_e.sel);
            end else begin
               $display("tick cycle %0d fast/slow/sel=%b%b%b ok", cyc, tick_fast, tick_slow, tick_sel);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached at cycle %0d, required finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, c2;

      #1 rst_n = 1'b0;
      wait_until(3);
      chk("rst_state", 32'(state), 0);
      chk("rst_tick_fast", 32'(tick_fast), 0);
      chk("rst_tick_slow", 32'(tick_slow), 0);
      chk("rst_sq_fast", 32'(sq_fast), 1);
      chk("rst_sq_slow", 32'(sq_slow), 1);
      rst_n = 1'b1;
      wait_until(5);

      // Free run: first tick 10 cycles after RUN is visible, every 4th carries slow.
      c0 = cyc;
      run = 1'b1;
      for (int k = 0; k < 9; k++) push(c0 + 11 + 10 * k, (k % 4) == 3, 1'b1);
      wait_until(c0 + 1);
      chk("s1_state_run", 32'(state), 1);
      wait_until(c0 + 5);
      chk("s1_sq_fast_hi", 32'(sq_fast), 1);
      wait_until(c0 + 6);
      chk("s1_sq_fast_lo", 32'(sq_fast), 0);
      wait_until(c0 + 25);
      chk("s1_sq_slow_lo", 32'(sq_slow), 0);
      wait_until(c0 + 100);
      clear = 1'b1; run = 1'b0;          // lands on the terminal count: tick suppressed
      wait_until(c0 + 101);
      clear = 1'b0;
      chk("s1_clear_state", 32'(state), 0);
      chk("s1_clear_sq_fast", 32'(sq_fast), 1);

      // Pause after 7 counted cycles, resume 3 cycles short of a tick.
      c1 = cyc;
      run = 1'b1;
      push(c1 + 31, 1'b0, 1'b1);
      wait_until(c1 + 7);
      run = 1'b0;
      wait_until(c1 + 8);
      chk("s2_state_pause", 32'(state), 2);
      chk("s2_sq_fast_held", 32'(sq_fast), 0);
      wait_until(c1 + 20);
      chk("s2_still_pause", 32'(state), 2);
      wait_until(c1 + 27);
      run = 1'b1;
      wait_until(c1 + 28);
      chk("s2_resume_run", 32'(state), 1);
      wait_until(c1 + 31);
      clear = 1'b1; run = 1'b0;
      wait_until(c1 + 32);
      clear = 1'b0; run = 1'b1;
      wait_until(c1 + 33);
      run = 1'b0;
      wait_until(c1 + 34);

      // Single-step from PAUSE: four pulses then one held step.
      c2 = cyc;
      chk("s3_state_pause", 32'(state), 2);
      for (int k = 0; k < 5; k++) push(c2 + 4 + 4 * k, k == 3, 1'b1);
      for (int k = 0; k < 4; k++) begin
         wait_until(c2 + 2 + 4 * k);
         step = 1'b1;
         wait_until(c2 + 3 + 4 * k);
         step = 1'b0;
         chk("s3_state_step", 32'(state), 3);
      end
      wait_until(c2 + 18);
      step = 1'b1;
      wait_until(c2 + 19);
      chk("s3_held_step", 32'(state), 3);
      wait_until(c2 + 25);
      chk("s3_held_no_restep", 32'(state), 2);
      wait_until(c2 + 28);
      step = 1'b0;

      // Step and run together in PAUSE: run wins, no STEP.
      wait_until(c2 + 30);
      step = 1'b1; run = 1'b1;
      push(c2 + 41, 1'b0, 1'b1);
      push(c2 + 51, 1'b0, 1'b1);
      push(c2 + 61, 1'b1, 1'b1);
      push(c2 + 71, 1'b0, 1'b0);
      push(c2 + 81, 1'b0, 1'b0);
      push(c2 + 91, 1'b0, 1'b0);
      push(c2 + 101, 1'b1, 1'b1);
      wait_until(c2 + 31);
      step = 1'b0;
      chk("s3_run_beats_step", 32'(state), 1);

      // Rate select changed mid-period takes effect only after the next fast tick.
      wait_until(c2 + 46);
      sel_slow = 1'b1;

      // Clear at pre_cnt=6 with run held high.
      wait_until(c2 + 107);
      clear = 1'b1;
      push(c2 + 119, 1'b0, 1'b0);
      wait_until(c2 + 108);
      clear = 1'b0;
      chk("s5_clear_idle", 32'(state), 0);
      chk("s5_clear_sq_fast", 32'(sq_fast), 1);
      chk("s5_clear_sq_slow", 32'(sq_slow), 1);
      wait_until(c2 + 109);
      chk("s5_rerun", 32'(state), 1);

      // Asynchronous reset mid-cycle.
      wait_until(c2 + 126);
      chk("s6_pre_rst_sq_fast", 32'(sq_fast), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("s6_async_state", 32'(state), 0);
      chk("s6_async_sq_fast", 32'(sq_fast), 1);
      run = 1'b0;
      wait_until(c2 + 129);
      rst_n = 1'b1;
      wait_until(c2 + 160);
      chk("queue_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
